// File: rtl/sram_ctrl.sv
// Memory-side controller for a word-wide asynchronous SRAM behind the cache.
// Runs a fixed-wait read or write cycle per granted request and answers with ready_mem.
module sram_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_mem,
    input  logic              write_mem,
    input  logic [3:0]        mem_be,
    input  logic [31:0]       mem_adbus,
    output logic              grant_mem,
    output logic              ready_mem,
    inout  wire  [31:0]       mem_databus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [31:0]       sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] RD_LOAD = 4'(WAIT_RD - 1);
    localparam logic [3:0] WR_LOAD = 4'(WAIT_WR - 1);

    logic [1:0]        state_q,    state_d;
    logic              op_wr_q,    op_wr_d;
    logic              dropped_q,  dropped_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic [3:0]        be_q,       be_d;
    logic              grant_q,    grant_d;
    logic              ready_q,    ready_d;
    logic              ce_n_q,     ce_n_d;
    logic              oe_n_q,     oe_n_d;
    logic              we_n_q,     we_n_d;
    logic [3:0]        be_n_q,     be_n_d;
    logic              mem_drv_q,  mem_drv_d;
    logic              sram_drv_q, sram_drv_d;

    logic active_req;
    logic unused_adbus;

    // Address bits below the word boundary and above the SRAM range are ignored (aliasing).
    assign unused_adbus = ^{mem_adbus[31:ADDR_W+2], mem_adbus[1:0]};

    assign active_req = op_wr_q ? write_mem : read_mem;

    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        dropped_d  = dropped_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        be_d       = be_q;
        grant_d    = grant_q;
        ready_d    = ready_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        be_n_d     = be_n_q;
        mem_drv_d  = mem_drv_q;
        sram_drv_d = sram_drv_q;

        case (state_q)
            IDLE: begin
                if (write_mem || read_mem) begin
                    state_d   = GRANT;
                    grant_d   = 1'b1;
                    op_wr_d   = write_mem;
                    dropped_d = 1'b0;
                end
            end

            GRANT: begin
                addr_d  = mem_adbus[ADDR_W+1:2];
                wdata_d = mem_databus;
                be_d    = mem_be;
                cnt_d   = op_wr_q ? WR_LOAD : RD_LOAD;
                ce_n_d  = 1'b0;
                if (op_wr_q) begin
                    we_n_d     = 1'b0;
                    be_n_d     = ~mem_be;
                    sram_drv_d = 1'b1;
                end else begin
                    oe_n_d = 1'b0;
                    be_n_d = 4'b0000;
                end
                if (!active_req) begin
                    dropped_d = 1'b1;
                end
                state_d = ACCESS;
            end

            ACCESS: begin
                if (!active_req) begin
                    dropped_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    // Read data is sampled on the last edge of the OE pulse.
                    if (!op_wr_q) begin
                        rdata_d   = sram_data;
                        mem_drv_d = 1'b1;
                    end
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    be_n_d  = 4'b1111;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                // A request dropped early still gets exactly one DONE cycle.
                if (dropped_q || !active_req) begin
                    state_d    = IDLE;
                    grant_d    = 1'b0;
                    ready_d    = 1'b0;
                    mem_drv_d  = 1'b0;
                    sram_drv_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_wr_q    <= 1'b0;
            dropped_q  <= 1'b0;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            be_q       <= 4'h0;
            grant_q    <= 1'b0;
            ready_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'b1111;
            mem_drv_q  <= 1'b0;
            sram_drv_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            dropped_q  <= dropped_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            be_q       <= be_d;
            grant_q    <= grant_d;
            ready_q    <= ready_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            mem_drv_q  <= mem_drv_d;
            sram_drv_q <= sram_drv_d;
        end
    end

    assign grant_mem   = grant_q;
    assign ready_mem   = ready_q;
    assign sram_addr   = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_be_n   = be_n_q;

    assign mem_databus = mem_drv_q  ? rdata_q : 32'hzzzz_zzzz;
    assign sram_data   = sram_drv_q ? wdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed and randomised checks of sram_ctrl at two wait-state settings,
// each instance with its own behavioural SRAM and pulled-up buses.
module tb_sram_ctrl;

    logic clk;
    logic [1:0] rst;
    logic [1:0] rd_req;
    logic [1:0] wr_req;
    logic [1:0] tb_drv;
    logic [1:0][3:0]  be_in;
    logic [1:0][31:0] adbus;
    logic [1:0][31:0] tb_wd;

    logic [1:0]        grant_v, ready_v, ce_v, oe_v, we_v;
    logic [1:0][3:0]   ben_v;
    logic [1:0][17:0]  saddr_v;
    logic [1:0][31:0]  mbus_v, sbus_v;

    logic [31:0] ref_mem [2][64];

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        wire  [31:0] mem_databus;
        wire  [31:0] sram_data;
        logic [17:0] sram_addr;
        logic        grant_mem, ready_mem, sram_ce_n, sram_oe_n, sram_we_n;
        logic [3:0]  sram_be_n;
        logic [31:0] mem [0:1023];

        sram_ctrl #(
            .ADDR_W (18),
            .WAIT_RD((gi == 0) ? 2 : 1),
            .WAIT_WR((gi == 0) ? 2 : 5)
        ) u_dut (
            .clk        (clk),
            .reset      (rst[gi]),
            .read_mem   (rd_req[gi]),
            .write_mem  (wr_req[gi]),
            .mem_be     (be_in[gi]),
            .mem_adbus  (adbus[gi]),
            .grant_mem  (grant_mem),
            .ready_mem  (ready_mem),
            .mem_databus(mem_databus),
            .sram_addr  (sram_addr),
            .sram_data  (sram_data),
            .sram_ce_n  (sram_ce_n),
            .sram_oe_n  (sram_oe_n),
            .sram_we_n  (sram_we_n),
            .sram_be_n  (sram_be_n)
        );

        for (genvar bi = 0; bi < 32; bi++) begin : g_pull
            pullup pu_m (mem_databus[bi]);
            pullup pu_s (sram_data[bi]);
        end

        assign mem_databus = tb_drv[gi] ? tb_wd[gi] : 32'hzzzz_zzzz;
        assign sram_data   = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 32'hzzzz_zzzz;

        always @(posedge clk) begin
            if (rst[gi]) begin
                for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
            end else if (!sram_ce_n && !sram_we_n) begin
                for (int l = 0; l < 4; l++)
                    if (!sram_be_n[l]) mem[sram_addr[9:0]][8*l +: 8] <= sram_data[8*l +: 8];
            end
        end

        assign grant_v[gi] = grant_mem;
        assign ready_v[gi] = ready_mem;
        assign ce_v[gi]    = sram_ce_n;
        assign oe_v[gi]    = sram_oe_n;
        assign we_v[gi]    = sram_we_n;
        assign ben_v[gi]   = sram_be_n;
        assign saddr_v[gi] = sram_addr;
        assign mbus_v[gi]  = mem_databus;
        assign sbus_v[gi]  = sram_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic ref_write(input int s, input int word, input logic [31:0] data, input logic [3:0] be);
        for (int l = 0; l < 4; l++)
            if (be[l]) ref_mem[s][word][8*l +: 8] = data[8*l +: 8];
    endtask

    // One complete handshake; checks latency, strobe widths, DONE hold and release.
    task automatic xfer(input int s, input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, output logic [31:0] rdata);
        int lat, oe_cnt, we_cnt, wait_n;
        bit seen;
        logic [3:0] exp_ben;
        wait_n  = wr ? ((s == 0) ? 2 : 5) : ((s == 0) ? 2 : 1);
        exp_ben = wr ? ~be : 4'h0;
        @(negedge clk);
        rd_req[s] = rd; wr_req[s] = wr; adbus[s] = addr; be_in[s] = be;
        tb_wd[s]  = data; tb_drv[s] = wr;
        lat = 0; oe_cnt = 0; we_cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (!oe_v[s]) oe_cnt++;
            if (!we_v[s]) we_cnt++;
            if (lat == 2) begin
                check_eq("sram_addr", 32'(saddr_v[s]), 32'(addr[19:2]));
                check_eq("sram_be_n", 32'(ben_v[s]), 32'(exp_ben));
                check_eq("sram_ce_n", 32'(ce_v[s]), 32'h0);
            end
            if (ready_v[s]) seen = 1;
        end
        check_eq("ready_seen", 32'(seen), 32'h1);
        check_eq("latency", lat, wait_n + 2);
        check_eq("grant_done", 32'(grant_v[s]), 32'h1);
        rdata = mbus_v[s];
        @(posedge clk); #1;
        if (!oe_v[s]) oe_cnt++;
        if (!we_v[s]) we_cnt++;
        check_eq("ready_hold", 32'(ready_v[s]), 32'h1);
        if (wr) check_eq("sram_data_hold", sbus_v[s], data);
        else    check_eq("rdata_stable", mbus_v[s], rdata);
        check_eq("oe_pulse", oe_cnt, wr ? 0 : wait_n);
        check_eq("we_pulse", we_cnt, wr ? wait_n : 0);
        rd_req[s] = 1'b0; wr_req[s] = 1'b0; tb_drv[s] = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_clear", 32'(ready_v[s]), 32'h0);
        check_eq("grant_clear", 32'(grant_v[s]), 32'h0);
        check_eq("mem_bus_float", mbus_v[s], 32'hFFFF_FFFF);
        check_eq("sram_bus_float", sbus_v[s], 32'hFFFF_FFFF);
    endtask

    initial begin
        logic [31:0] rdata, addr, data;
        logic [3:0]  be;
        logic        wr;
        int          word, pulses;

        n_checks = 0; n_errors = 0;
        rst = 2'b11; rd_req = '0; wr_req = '0; tb_drv = '0;
        be_in = '1; adbus = '0; tb_wd = '0;
        for (int s = 0; s < 2; s++) for (int w = 0; w < 64; w++) ref_mem[s][w] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_grant", 32'(grant_v[s]), 32'h0);
            check_eq("rst_ready", 32'(ready_v[s]), 32'h0);
            check_eq("rst_ce_n", 32'(ce_v[s]), 32'h1);
            check_eq("rst_oe_n", 32'(oe_v[s]), 32'h1);
            check_eq("rst_we_n", 32'(we_v[s]), 32'h1);
            check_eq("rst_be_n", 32'(ben_v[s]), 32'hF);
            check_eq("rst_addr", 32'(saddr_v[s]), 32'h0);
            check_eq("rst_mem_bus", mbus_v[s], 32'hFFFF_FFFF);
            check_eq("rst_sram_bus", sbus_v[s], 32'hFFFF_FFFF);
        end

        // Preload word 0x10 then read it back at byte address 0x40.
        xfer(0, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'hF, rdata); ref_write(0, 16, 32'hDEAD_BEEF, 4'hF);
        xfer(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, rdata);
        check_eq("read_0x40", rdata, 32'hDEAD_BEEF);

        // Partial write: only byte lane 2 of word 0x11 changes.
        xfer(0, 1'b1, 1'b0, 32'h44, 32'hAABB_CCDD, 4'hF, rdata); ref_write(0, 17, 32'hAABB_CCDD, 4'hF);
        xfer(0, 1'b1, 1'b0, 32'h44, 32'h1234_5678, 4'b0100, rdata); ref_write(0, 17, 32'h1234_5678, 4'b0100);
        check_eq("sram_word_0x11", g_inst[0].mem[17], 32'hAA34_CCDD);
        xfer(0, 1'b0, 1'b1, 32'h44, 32'h0, 4'hF, rdata);
        check_eq("read_merged", rdata, 32'hAA34_CCDD);

        // Simultaneous read and write requests: the write wins.
        xfer(0, 1'b1, 1'b1, 32'h48, 32'h0BAD_F00D, 4'hF, rdata); ref_write(0, 18, 32'h0BAD_F00D, 4'hF);
        xfer(0, 1'b0, 1'b1, 32'h48, 32'h0, 4'hF, rdata);
        check_eq("read_both_hi", rdata, 32'h0BAD_F00D);

        // Request withdrawn right after grant: exactly one ready pulse.
        @(negedge clk); rd_req[0] = 1'b1; adbus[0] = 32'h40;
        @(posedge clk); #1;
        check_eq("viol_grant", 32'(grant_v[0]), 32'h1);
        rd_req[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ready_v[0]) pulses++;
        end
        check_eq("viol_ready_pulses", pulses, 1);
        check_eq("viol_grant_end", 32'(grant_v[0]), 32'h0);

        // Reset during the ACCESS phase of a write.
        @(negedge clk); wr_req[0] = 1'b1; adbus[0] = 32'h4C; tb_wd[0] = 32'h5555_AAAA; tb_drv[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("abort_we_low", 32'(we_v[0]), 32'h0);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_we_n", 32'(we_v[0]), 32'h1);
        check_eq("abort_ce_n", 32'(ce_v[0]), 32'h1);
        check_eq("abort_grant", 32'(grant_v[0]), 32'h0);
        check_eq("abort_state", 32'(g_inst[0].u_dut.state_q), 32'h0);
        rst[0] = 1'b0; wr_req[0] = 1'b0; tb_drv[0] = 1'b0;
        for (int w = 0; w < 64; w++) ref_mem[0][w] = 32'h0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ready_v[0]) pulses++;
        end
        check_eq("abort_no_ready", pulses, 0);
        check_eq("abort_sram_bus", sbus_v[0], 32'hFFFF_FFFF);

        // Short-read / long-write instance, directed then random on both.
        xfer(1, 1'b1, 1'b0, 32'h80, 32'hCAFE_0123, 4'hF, rdata); ref_write(1, 32, 32'hCAFE_0123, 4'hF);
        xfer(1, 1'b0, 1'b1, 32'h80, 32'h0, 4'hF, rdata);
        check_eq("s1_read", rdata, 32'hCAFE_0123);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 100; i++) begin
                word = $urandom_range(0, 63);
                addr = ($urandom & 32'hFFF0_0000) | 32'(word << 2) | 32'($urandom_range(0, 3));
                data = $urandom;
                be   = 4'($urandom_range(0, 15));
                wr   = 1'($urandom_range(0, 1));
                if (wr) begin
                    xfer(s, 1'b1, 1'($urandom_range(0, 1)), addr, data, be, rdata);
                    ref_write(s, word, data, be);
                end else begin
                    xfer(s, 1'b0, 1'b1, addr, 32'h0, 4'hF, rdata);
                    check_eq("rand_read", rdata, ref_mem[s][word]);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
